// File: rtl/dump_off_pkg.sv
// dump_off_pkg: shared states, error bits, phase codes and timing defaults for the dump-off link
package dump_off_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW, ST_DONE} state_e;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_HIGH = 1;
  localparam int ERR_LOW = 2;
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_ARM = 2'd1;
  localparam logic [1:0] PH_HIGH = 2'd2;
  localparam logic [1:0] PH_LOW = 2'd3;
  localparam int DEF_CNT_W = 5;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HIGH_MIN = 4;
  localparam int DEF_HIGH_MAX = 20;
  localparam int DEF_LOW_MIN = 8;
  localparam int DEF_TIMEOUT = 31;
  function automatic logic [1:0] phase_of(input state_e s);
    return s == ST_ARM ? PH_ARM : s == ST_HIGH ? PH_HIGH : s == ST_LOW ? PH_LOW : PH_IDLE;
  endfunction
endpackage

// File: rtl/dump_off_monitor_bit_sync.sv
// bit_sync: multi-stage synchroniser with a trailing flop for rising-edge detection
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic s_d_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      s_d_q <= sync_q[STAGES-1];
    end
  end
  assign s_o = sync_q[STAGES-1];
  assign rise_o = s_o & ~s_d_q;
endmodule

// File: rtl/dump_off_monitor.sv
// dump_off_monitor: measures dump-off high pulse and low guard after each state_start
module dump_off_monitor
  import dump_off_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HIGH_MIN = DEF_HIGH_MIN,
  parameter int HIGH_MAX = DEF_HIGH_MAX,
  parameter int LOW_MIN = DEF_LOW_MIN,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             state_start,
  input  logic             dump_in,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] high_width,
  output logic [CNT_W-1:0] low_width,
  output logic             seq_done,
  output logic             seq_ok,
  output logic [2:0]       err,
  output logic             busy
);
  localparam logic [CNT_W-1:0] HMIN = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] LMIN = CNT_W'(LOW_MIN);
  localparam logic [CNT_W-1:0] TOUT = CNT_W'(TIMEOUT);
  logic dump_s, rise;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hw_q, hw_d, lw_q, lw_d;
  logic [2:0] err_q, err_d;
  logic ok_q, ok_d, done_q, busy_q;
  logic [1:0] phase_q;
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_sys), .rst(rst), .d_i(dump_in), .s_o(dump_s), .rise_o(rise)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hw_d = hw_q;
    lw_d = lw_q;
    err_d = err_q;
    ok_d = ok_q;
    if (state_start) begin
      state_d = ST_ARM;
      cnt_d = '0;
      hw_d = '0;
      lw_d = '0;
      err_d = '0;
      ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARM:
          if (rise) begin
            cnt_d = CNT_W'(1);
            state_d = ST_HIGH;
          end else if (cnt_q == TOUT) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d = ST_DONE;
          end else cnt_d = cnt_q + 1'b1;
        ST_HIGH:
          if (dump_s && cnt_q >= HMAX) begin
            hw_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            err_d[ERR_HIGH] = 1'b1;
            state_d = ST_DONE;
          end else if (dump_s) cnt_d = cnt_q + 1'b1;
          else begin
            hw_d = cnt_q;
            err_d[ERR_HIGH] = cnt_q < HMIN;
            cnt_d = CNT_W'(1);
            state_d = ST_LOW;
          end
        ST_LOW:
          if (dump_s || cnt_q == LMIN) begin
            lw_d = cnt_q;
            err_d[ERR_LOW] = err_q[ERR_LOW] | dump_s;
            state_d = ST_DONE;
          end else cnt_d = cnt_q + 1'b1;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_DONE) ok_d = err_d == 3'b000;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      hw_q <= '0;
      lw_q <= '0;
      err_q <= '0;
      ok_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      phase_q <= PH_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hw_q <= hw_d;
      lw_q <= lw_d;
      err_q <= err_d;
      ok_q <= ok_d;
      done_q <= state_d == ST_DONE;
      busy_q <= state_d inside {ST_ARM, ST_HIGH, ST_LOW};
      phase_q <= phase_of(state_d);
    end
  end
  assign phase = phase_q;
  assign high_width = hw_q;
  assign low_width = lw_q;
  assign seq_done = done_q;
  assign seq_ok = ok_q;
  assign err = err_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_dump_off_monitor.sv
// tb_dump_off_monitor: directed sequences with a result scoreboard popped on seq_done
module tb_dump_off_monitor;
  import dump_off_pkg::*;
  localparam int W = 5;
  logic clk_sys = 1'b0, rst = 1'b1, state_start = 1'b0, dump_in = 1'b0;
  logic [1:0] phase;
  logic [W-1:0] high_width, low_width;
  logic seq_done, seq_ok, busy;
  logic [2:0] err;
  typedef struct packed {
    logic [W-1:0] hw;
    logic [W-1:0] lw;
    logic [2:0] e;
    logic ok;
  } res_t;
  res_t sb[$];
  res_t r_exp;
  int tests = 0, fails = 0;

  always #5 clk_sys = ~clk_sys;

  dump_off_monitor #(
    .CNT_W(W), .SYNC_STAGES(2), .HIGH_MIN(4), .HIGH_MAX(20), .LOW_MIN(8), .TIMEOUT(31)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .state_start(state_start), .dump_in(dump_in),
    .phase(phase), .high_width(high_width), .low_width(low_width), .seq_done(seq_done),
    .seq_ok(seq_ok), .err(err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic start();
    state_start = 1'b1;
    tick();
    state_start = 1'b0;
  endtask

  task automatic drive(input logic v, input int n);
    dump_in = v;
    tick(n);
  endtask

  task automatic expect_res(input int hw, input int lw, input int e, input logic ok);
    sb.push_back('{hw: W'(hw), lw: W'(lw), e: 3'(e), ok: ok});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
    check({"drain_", tag}, sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk_sys) begin
    if (seq_done) begin
      check("done_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        r_exp = sb.pop_front();
        check("high_width", high_width, r_exp.hw);
        check("low_width", low_width, r_exp.lw);
        check("err", err, r_exp.e);
        check("seq_ok", seq_ok, r_exp.ok);
      end
    end
  end

  initial begin
    tick(3);
    check("reset_outs", {phase, high_width, low_width, seq_done, seq_ok, err, busy}, 0);
    rst = 1'b0;
    tick(2);
    // legal 10-cycle pulse
    expect_res(10, 8, 0, 1'b1);
    start();
    check("arm_phase", phase, PH_ARM);
    check("arm_busy", busy, 1);
    drive(1'b1, 10);
    drive(1'b0, 2);
    drain("legal10");
    tick(3);
    check("ok_held", seq_ok, 1);
    check("hw_held", high_width, 10);
    check("idle_busy", busy, 0);
    // no pulse: timeout
    expect_res(0, 0, 1, 1'b0);
    start();
    drain("timeout");
    check("timeout_phase", phase, PH_IDLE);
    // width bounds
    tick(2);
    expect_res(3, 8, 2, 1'b0);
    start();
    drive(1'b1, 3);
    drive(1'b0, 1);
    drain("short3");
    tick(2);
    expect_res(21, 0, 2, 1'b0);
    start();
    drive(1'b1, 21);
    drain("long21");
    check("long_idle_while_high", phase, PH_IDLE);
    drive(1'b0, 4);
    expect_res(4, 8, 0, 1'b1);
    start();
    drive(1'b1, 4);
    drive(1'b0, 1);
    drain("min4");
    tick(2);
    expect_res(20, 8, 0, 1'b1);
    start();
    drive(1'b1, 20);
    drive(1'b0, 1);
    drain("max20");
    tick(2);
    // guard violation
    expect_res(10, 5, 4, 1'b0);
    start();
    drive(1'b1, 10);
    drive(1'b0, 5);
    drive(1'b1, 3);
    dump_in = 1'b0;
    drain("guard");
    tick(4);
    // restart during HIGH
    start();
    drive(1'b1, 4);
    check("restart_pre_phase", phase, PH_HIGH);
    dump_in = 1'b0;
    start();
    check("restart_phase", phase, PH_ARM);
    check("restart_clear", {high_width, low_width, err, seq_ok}, 0);
    check("restart_busy", busy, 1);
    expect_res(6, 8, 0, 1'b1);
    drive(1'b0, 3);
    drive(1'b1, 6);
    drive(1'b0, 1);
    drain("after_restart");
    tick(2);
    // reset during LOW
    start();
    drive(1'b1, 5);
    drive(1'b0, 3);
    check("low_phase", phase, PH_LOW);
    check("low_hw", high_width, 5);
    rst = 1'b1;
    tick();
    check("midrst_outs", {phase, high_width, low_width, seq_done, seq_ok, err, busy}, 0);
    rst = 1'b0;
    tick(12);
    // back-to-back
    expect_res(7, 8, 0, 1'b1);
    start();
    drive(1'b1, 7);
    dump_in = 1'b0;
    for (int i = 0; i < 40 && !seq_done; i++) tick();
    check("b2b_first_done", seq_done, 1);
    expect_res(12, 8, 0, 1'b1);
    tick();
    start();
    drive(1'b1, 12);
    drive(1'b0, 1);
    drain("b2b_second");
    tick(5);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dump_off_monitor.md
Name: dump_off_monitor

Overview:
- Receive-side checker for the dump-off control pulse produced by the DUMP_OFF generator.
- After each state_start it arms, synchronises the incoming dump line, and measures the off (high) pulse width and the following low guard time.
- Reports the measured widths, a completion strobe, and pass/fail error flags to the sequencer/status registers in the NMR control FPGA.

Parameters:
CNT_W, 5, width of the cycle counter and width outputs
SYNC_STAGES, 2, flip-flop stages on dump_in (minimum 2)
HIGH_MIN, 4, minimum legal high width in clk_sys cycles
HIGH_MAX, 20, maximum legal high width; requires HIGH_MAX+1 <= 2^CNT_W-1
LOW_MIN, 8, required low guard cycles after the falling edge
TIMEOUT, 31, ARM cycles allowed before the rising edge; requires TIMEOUT <= 2^CNT_W-1

Ports:
clk_sys  in  1  system clock; sole clock
rst  in  1  synchronous, active-high reset
state_start  in  1  one-cycle pulse; arms or re-arms the monitor
dump_in  in  1  dump_off line under observation (asynchronous to the checker)
phase  out  2  0=IDLE/DONE, 1=ARM, 2=HIGH, 3=LOW
high_width  out  CNT_W  measured high cycles, held until the next state_start
low_width  out  CNT_W  measured low cycles, held until the next state_start
seq_done  out  1  one-cycle strobe at sequence end
seq_ok  out  1  valid with seq_done; 1 when err==0, held afterwards
err  out  3  bit0 no-rise timeout, bit1 high width illegal, bit2 low guard violated; sticky until the next state_start
busy  out  1  1 in ARM/HIGH/LOW

Behaviour:
- Reset: applied on the clk_sys edge while rst=1. All outputs 0; state IDLE; counter 0; synchroniser and edge flop cleared to 0. Reset mid-sequence aborts with no seq_done.
- Synchroniser: dump_s = dump_in delayed SYNC_STAGES cycles. rise = dump_s & ~dump_s_d; all decisions use dump_s.
- State machine: IDLE, ARM, HIGH, LOW, DONE; all outputs registered.
- IDLE: on state_start, clear err/high_width/low_width/seq_ok, cnt<=0, go to ARM.
- ARM:
  - rise: cnt<=1, go to HIGH.
  - else cnt==TIMEOUT: err[0]<=1, go to DONE.
  - else cnt++.
- HIGH:
  - dump_s=1 and cnt+1>HIGH_MAX: high_width<=cnt+1 (saturating at 2^CNT_W-1), err[1]<=1, go to DONE.
  - dump_s=1 otherwise: cnt++.
  - dump_s=0: high_width<=cnt; err[1]<=(cnt<HIGH_MIN); cnt<=1; go to LOW.
  - An N-cycle high on dump_s reports high_width=N.
- LOW:
  - dump_s=1: low_width<=cnt, err[2]<=1, go to DONE.
  - else cnt==LOW_MIN: low_width<=cnt, go to DONE.
  - else cnt++.
- DONE: exactly one cycle. seq_done=1; seq_ok=(err==0); then IDLE. seq_ok holds until the next state_start.
- state_start in ARM/HIGH/LOW/DONE: restart. Results clear and the next state is ARM; no seq_done for the aborted sequence.
- state_start and rst in the same cycle: rst wins.
- Counter never wraps; every compare is against a value below the saturation point.
- Latency:
  - dump_in edge to measurement is SYNC_STAGES+1 cycles.
  - seq_done comes 1 cycle after the terminating condition is seen.
- Widths and err are stable whenever busy=0.

Decomposition:
- Shared package dump_off_pkg:
  - state enum (IDLE, ARM, HIGH, LOW, DONE)
  - err bit index constants (ERR_TIMEOUT=0, ERR_HIGH=1, ERR_LOW=2)
  - phase encoding constants
  - default timing constants, also used by the generator side
- One natural sub-module: bit_sync (SYNC_STAGES-deep synchroniser plus edge-detect flop, reset to 0).

Test Plan:
1. Legal pulse: state_start, dump_in high 10 cycles, then low ≥8 -> high_width=10, low_width=8, seq_done pulse, seq_ok=1, err=000.
2. No pulse: state_start, dump_in held 0 -> after 32 ARM cycles seq_done=1, err=001, seq_ok=0, high_width=0.
3. Width bounds: high 3 cycles -> err=010, high_width=3. High 21+ cycles -> DONE entered with high_width=21, err=010, without waiting for the fall. Highs of 4 and 20 -> err=000.
4. Guard violation: high 10, low 5, high again -> low_width=5, err=100, seq_ok=0.
5. Restart/reset: state_start issued during HIGH -> no seq_done, outputs cleared, phase=1; a following legal 6-cycle pulse reports high_width=6. rst asserted in LOW -> all outputs 0 next cycle, no seq_done.
6. Back-to-back: two legal sequences (7 then 12 high cycles) with state_start one cycle after the first seq_done -> two seq_done strobes, high_width=7 then 12, seq_ok=1 both.
